code_checker: RTL and testbench
===============================

CODE_CHECKER -- requirements
Module: code_checker

Interface
REQ-001 Parameter MAX_DIGITS, 4: maximum number of digits held in the entry buffer and in the password.
REQ-002 Parameter DIGIT_W, 4: width of one digit in bits.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 system_reset  input  1  asynchronous, active-low reset.
REQ-005 resetSignal  input  1  synchronous active-low clear from the controller.
REQ-006 ld_input  input  1  active-high entry mode from the controller.
REQ-007 digit_valid  input  1  one-cycle strobe; digit is valid.
REQ-008 digit  input  DIGIT_W  entered digit value.
REQ-009 compareSignal  input  1  compare request from the controller; level, held high until doneCompare is seen.
REQ-010 pass_word  input  MAX_DIGITS*DIGIT_W  stored password from the setup panel; digit i is at bits [i*DIGIT_W +: DIGIT_W].
REQ-011 pass_len  input  3  stored password length, 0..MAX_DIGITS.
REQ-012 doneCompare  output  1  one-cycle pulse; comparison finished.
REQ-013 match  output  1  result of the last comparison; held until cleared.
REQ-014 entry_len  output  3  number of digits currently buffered.
REQ-015 entry_full  output  1  high when entry_len == MAX_DIGITS.
REQ-016 fail_count  output  2  consecutive failed comparisons, saturating at 3.

Function
REQ-017 The block SHALL use a three-state FSM: IDLE, COMPARE and DONE.
REQ-018 In IDLE with ld_input=1, digit_valid=1 and entry_full=0, the block SHALL write digit to buffer slot entry_len and increment entry_len in the same edge.
REQ-019 When entry_full=1, or ld_input=0, or the FSM is not in IDLE, the block SHALL ignore digit_valid; entry_len saturates at MAX_DIGITS.
REQ-020 The block SHALL register compareSignal and start only on its rising edge: IDLE with compareSignal=1 and previous=0 SHALL set an index to 0.
REQ-021 On a start edge where entry_len != pass_len, pass_len == 0, or pass_len > MAX_DIGITS, the FSM SHALL go directly to DONE with the result set to fail.
REQ-022 On any other start edge the FSM SHALL enter COMPARE and compare one digit per cycle, buffer[idx] against pass_word digit idx, for idx 0..pass_len-1.
REQ-023 Any digit mismatch SHALL set a sticky fail flag; COMPARE SHALL NOT terminate early and SHALL always last exactly pass_len cycles.
REQ-024 After the last index, the FSM SHALL enter DONE; DONE SHALL last one cycle, assert doneCompare=1, and return to IDLE.
REQ-025 Latency: the doneCompare cycle SHALL be pass_len+1 cycles after the start-edge cycle, or 1 cycle after it on an early fail.
REQ-026 At the DONE edge, match SHALL be set to 1 on success and 0 on fail.
REQ-027 At the DONE edge, fail_count SHALL clear to 0 on success and increment on fail, saturating at 3.
REQ-028 At the DONE edge, the entry buffer and entry_len SHALL clear so that the next attempt starts empty.
REQ-029 compareSignal still high after DONE SHALL NOT restart a comparison; a new start requires a low cycle first.
REQ-030 pass_word and pass_len SHALL be sampled live during COMPARE; the setup panel holds them stable.

Reset
REQ-031 system_reset=0 SHALL asynchronously force: FSM=IDLE, entry_len=0, buffer=0, doneCompare=0, match=0, fail_count=0, registered compareSignal=0.
REQ-032 resetSignal=0 SHALL synchronously force: FSM=IDLE, entry_len=0, doneCompare=0, and registered compareSignal=0.
REQ-033 resetSignal=0 SHALL NOT change match or fail_count, including when it aborts a COMPARE in progress with no doneCompare.
REQ-034 resetSignal=0 SHALL take priority over digit writes and start edges in the same cycle.

Verification
REQ-035 pass_word=0x4321, pass_len=4, enter 1,2,3,4, raise compareSignal -> COMPARE 4 cycles; doneCompare pulses on cycle 5; match=1; fail_count=0; entry_len=0.
REQ-036 Same password, enter 1,2,9,4 -> doneCompare after 5 cycles, match=0, fail_count=1; repeat 3 more times -> fail_count stays 3.
REQ-037 pass_len=4, enter 3 digits, compare -> doneCompare on the next cycle, match=0.
REQ-038 Enter 6 digits with ld_input=1 -> entry_len=4 and entry_full=1; digits 5-6 are dropped; a digit with ld_input=0 is ignored.
REQ-039 Hold compareSignal high 10 cycles after doneCompare -> exactly one doneCompare pulse.
REQ-040 Pulse resetSignal=0 mid-COMPARE -> IDLE the next cycle, no doneCompare, match and fail_count unchanged; system_reset=0 mid-cycle clears all outputs immediately.

Source files
------------

// File: rtl/code_checker.sv
// Entry buffer and password comparator: digits are buffered while idle, then
// checked one digit per cycle against the stored password on a compare request.

module code_slot #(
  parameter int DIGIT_W = 4
) (
  input  logic               clock,
  input  logic               system_reset,
  input  logic               wr,
  input  logic               clr,
  input  logic [DIGIT_W-1:0] din,
  input  logic [DIGIT_W-1:0] ref_digit,
  output logic [DIGIT_W-1:0] value,
  output logic               eq
);
  always_ff @(posedge clock or negedge system_reset) begin
    if (!system_reset)  value <= '0;
    else if (clr)       value <= '0;
    else if (wr)        value <= din;
  end

  assign eq = (value == ref_digit);
endmodule

module code_checker #(
  parameter int MAX_DIGITS = 4,
  parameter int DIGIT_W    = 4
) (
  input  logic                          clock,
  input  logic                          system_reset,
  input  logic                          resetSignal,
  input  logic                          ld_input,
  input  logic                          digit_valid,
  input  logic [DIGIT_W-1:0]            digit,
  input  logic                          compareSignal,
  input  logic [MAX_DIGITS*DIGIT_W-1:0] pass_word,
  input  logic [2:0]                    pass_len,
  output logic                          doneCompare,
  output logic                          match,
  output logic [2:0]                    entry_len,
  output logic                          entry_full,
  output logic [1:0]                    fail_count
);
  localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic            fail_q, fail_d;
  logic            cmp_q;
  logic [2:0]      entry_len_q;
  logic            done_q;
  logic            match_q;
  logic [1:0]      fcnt_q;

  logic            start, early, wr_en, last, mism, finish, pass_ok;
  logic [MAX_DIGITS-1:0] eq_vec;

  assign entry_full = (entry_len_q == 3'(MAX_DIGITS));
  assign start      = (state_q == IDLE) && compareSignal && !cmp_q;
  assign early      = (entry_len_q != pass_len) || (pass_len == 3'd0) ||
                      (pass_len > 3'(MAX_DIGITS));
  // a start edge wins over a digit strobe landing in the same cycle
  assign wr_en      = (state_q == IDLE) && ld_input && digit_valid && !entry_full && !start;
  assign last       = (idx_q + 3'd1) >= pass_len;
  assign mism       = (idx_q < 3'(MAX_DIGITS)) ? !eq_vec[idx_q[IDX_W-1:0]] : 1'b1;
  assign finish     = ((state_q == IDLE) && start && early) ||
                      ((state_q == COMPARE) && last);
  assign pass_ok    = (state_q == COMPARE) && !(fail_q || mism);

  genvar i;
  generate
    for (i = 0; i < MAX_DIGITS; i++) begin : g_slot
      code_slot #(.DIGIT_W(DIGIT_W)) u_slot (
        .clock        (clock),
        .system_reset (system_reset),
        .wr           (wr_en && resetSignal && (entry_len_q == 3'(i))),
        .clr          (finish && resetSignal),
        .din          (digit),
        .ref_digit    (pass_word[i*DIGIT_W +: DIGIT_W]),
        .value        (),
        .eq           (eq_vec[i])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = 3'd0;
          fail_d  = 1'b0;
          state_d = early ? DONE : COMPARE;
        end
      end
      COMPARE: begin
        // no early exit: the walk always covers pass_len digits
        fail_d = fail_q | mism;
        idx_d  = idx_q + 3'd1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge system_reset) begin
    if (!system_reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      fail_q      <= 1'b0;
      cmp_q       <= 1'b0;
      entry_len_q <= '0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      fcnt_q      <= '0;
    end else if (!resetSignal) begin
      // controller clear leaves the last result and fail history intact
      state_q     <= IDLE;
      idx_q       <= '0;
      fail_q      <= 1'b0;
      cmp_q       <= 1'b0;
      entry_len_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      cmp_q   <= compareSignal;
      done_q  <= (state_d == DONE);
      if (finish) begin
        match_q     <= pass_ok;
        fcnt_q      <= pass_ok ? 2'd0 : ((fcnt_q == 2'd3) ? 2'd3 : fcnt_q + 2'd1);
        entry_len_q <= '0;
      end else if (wr_en) begin
        entry_len_q <= entry_len_q + 3'd1;
      end
    end
  end

  assign doneCompare = done_q;
  assign match       = match_q;
  assign entry_len   = entry_len_q;
  assign fail_count  = fcnt_q;
endmodule

// File: tb/tb_code_checker.sv
// Directed bench for code_checker: table of compare attempts plus hand-written
// sequences for compare-hold, controller clear and asynchronous reset.

module tb_code_checker;
  logic        clock = 1'b0;
  logic        system_reset;
  logic        resetSignal;
  logic        ld_input;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        compareSignal;
  logic [15:0] pass_word;
  logic [2:0]  pass_len;
  logic        doneCompare;
  logic        match;
  logic [2:0]  entry_len;
  logic        entry_full;
  logic [1:0]  fail_count;

  int tests = 0;
  int fails = 0;

  code_checker #(.MAX_DIGITS(4), .DIGIT_W(4)) dut (
    .clock         (clock),
    .system_reset  (system_reset),
    .resetSignal   (resetSignal),
    .ld_input      (ld_input),
    .digit_valid   (digit_valid),
    .digit         (digit),
    .compareSignal (compareSignal),
    .pass_word     (pass_word),
    .pass_len      (pass_len),
    .doneCompare   (doneCompare),
    .match         (match),
    .entry_len     (entry_len),
    .entry_full    (entry_full),
    .fail_count    (fail_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          n;
    logic [23:0] digs;
    logic [15:0] pw;
    logic [2:0]  plen;
    int          lat;
    logic        m;
    logic [1:0]  fc;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic enter(input logic [3:0] d);
    digit       = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic run_attempt(input vec_t v, input int id);
    int lat;
    int exp_len;
    pass_word = v.pw;
    pass_len  = v.plen;
    for (int k = 0; k < v.n; k++) enter(v.digs[k*4 +: 4]);
    exp_len = (v.n > 4) ? 4 : v.n;
    chk($sformatf("v%0d entry_len", id), int'(entry_len), exp_len);
    chk($sformatf("v%0d entry_full", id), int'(entry_full), int'(exp_len == 4));
    compareSignal = 1'b1;
    tick();
    lat = 1;
    while (!doneCompare && lat < 20) begin
      tick();
      lat++;
    end
    if (!doneCompare) lat = -1;
    chk($sformatf("v%0d latency", id), lat, v.lat);
    chk($sformatf("v%0d match", id), int'(match), int'(v.m));
    chk($sformatf("v%0d fail_count", id), int'(fail_count), int'(v.fc));
    chk($sformatf("v%0d entry_cleared", id), int'(entry_len), 0);
    compareSignal = 1'b0;
    tick();
    chk($sformatf("v%0d done_one_cycle", id), int'(doneCompare), 0);
  endtask

  initial begin
    int pulses;
    vec_t v;

    tbl[0]  = '{4, 24'h004321, 16'h4321, 3'd4, 5, 1'b1, 2'd0};
    tbl[1]  = '{4, 24'h004921, 16'h4321, 3'd4, 5, 1'b0, 2'd1};
    tbl[2]  = '{4, 24'h004921, 16'h4321, 3'd4, 5, 1'b0, 2'd2};
    tbl[3]  = '{4, 24'h004921, 16'h4321, 3'd4, 5, 1'b0, 2'd3};
    tbl[4]  = '{4, 24'h004921, 16'h4321, 3'd4, 5, 1'b0, 2'd3};
    tbl[5]  = '{4, 24'h004321, 16'h4321, 3'd4, 5, 1'b1, 2'd0};
    tbl[6]  = '{3, 24'h000321, 16'h4321, 3'd4, 1, 1'b0, 2'd1};
    tbl[7]  = '{2, 24'h000021, 16'h0021, 3'd2, 3, 1'b1, 2'd0};
    tbl[8]  = '{0, 24'h000000, 16'h4321, 3'd0, 1, 1'b0, 2'd1};
    tbl[9]  = '{4, 24'h004321, 16'h4321, 3'd5, 1, 1'b0, 2'd2};
    tbl[10] = '{6, 24'h654321, 16'h4321, 3'd4, 5, 1'b1, 2'd0};
    tbl[11] = '{4, 24'h004320, 16'h4321, 3'd4, 5, 1'b0, 2'd1};
    tbl[12] = '{1, 24'h000007, 16'h0007, 3'd1, 2, 1'b1, 2'd0};

    system_reset  = 1'b0;
    resetSignal   = 1'b1;
    ld_input      = 1'b0;
    digit_valid   = 1'b0;
    digit         = 4'h0;
    compareSignal = 1'b0;
    pass_word     = 16'h4321;
    pass_len      = 3'd4;
    tick();
    tick();
    system_reset = 1'b1;
    tick();

    chk("rst doneCompare", int'(doneCompare), 0);
    chk("rst match", int'(match), 0);
    chk("rst entry_len", int'(entry_len), 0);
    chk("rst entry_full", int'(entry_full), 0);
    chk("rst fail_count", int'(fail_count), 0);

    enter(4'h3);
    chk("ld_input low ignores digit", int'(entry_len), 0);
    ld_input = 1'b1;

    for (int i = 0; i < 13; i++) run_attempt(tbl[i], i);

    // compare request held high long after completion gives a single pulse
    pass_word = 16'h4321;
    pass_len  = 3'd4;
    for (int k = 1; k <= 4; k++) enter(4'(k));
    compareSignal = 1'b1;
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (doneCompare) pulses++;
    end
    compareSignal = 1'b0;
    tick();
    chk("held compare pulses", pulses, 1);
    chk("held compare match", int'(match), 1);

    v = '{4, 24'h004921, 16'h4321, 3'd4, 5, 1'b0, 2'd1};
    run_attempt(v, 100);

    // controller clear in the middle of a compare
    for (int k = 1; k <= 4; k++) enter(4'(k));
    compareSignal = 1'b1;
    tick();
    tick();
    tick();
    resetSignal   = 1'b0;
    compareSignal = 1'b0;
    tick();
    chk("abort doneCompare", int'(doneCompare), 0);
    chk("abort entry_len", int'(entry_len), 0);
    chk("abort match kept", int'(match), 0);
    chk("abort fail_count kept", int'(fail_count), 1);
    resetSignal = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (doneCompare) pulses++;
    end
    chk("abort no late done", pulses, 0);
    chk("abort fail_count after", int'(fail_count), 1);

    // clear wins over a digit strobe in the same cycle
    resetSignal = 1'b0;
    enter(4'h5);
    resetSignal = 1'b1;
    chk("clear beats digit", int'(entry_len), 0);

    // asynchronous reset mid-cycle
    for (int k = 1; k <= 4; k++) enter(4'(k));
    chk("pre async entry_full", int'(entry_full), 1);
    #3;
    system_reset = 1'b0;
    #1;
    chk("async entry_len", int'(entry_len), 0);
    chk("async entry_full", int'(entry_full), 0);
    chk("async fail_count", int'(fail_count), 0);
    chk("async match", int'(match), 0);
    chk("async doneCompare", int'(doneCompare), 0);
    tick();
    system_reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
